// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bus of the two-master memory arbiter.
// A request is accepted in the cycle where reqN_valid and reqN_ready are both high. The master must hold
// we/addr/wdata stable while valid waits for ready. rspN_valid is a one-cycle completion pulse and carries rspN_rdata.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_data_out,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_data_out,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer giving two masters one-at-a-time access to a single-port memory.
// state_dbg exposes the FSM: 0=IDLE, 1=ACCESS, 2=WAIT, 3=RESP.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output logic         busy,
    output logic [1:0]   state_dbg
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              rr_ptr;
    logic              lat_we;
    logic              lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic [1:0]        req_valid;
    logic              winner;
    logic              grant;
    logic [1:0]        ready;
    logic [1:0]        rsp_valid;
    logic              mem_we;
    logic              mem_re;

    // With both masters requesting, rr_ptr picks; otherwise the lone requester wins.
    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign winner    = (&req_valid) ? rr_ptr : req_valid[1];
    assign grant     = (state == IDLE) && (|req_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ready     = 2'b00;
        rsp_valid = 2'b00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            IDLE: begin
                if (grant && rst_n) begin
                    ready    = winner ? 2'b10 : 2'b01;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_we   = lat_we;
                mem_re   = ~lat_we;
                state_nx = lat_we ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = lat_id ? 2'b10 : 2'b01;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            lat_we    <= 1'b0;
            lat_id    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            rr_ptr    <= ~winner;
            lat_id    <= winner;
            lat_we    <= winner ? bus.req1_we    : bus.req0_we;
            lat_addr  <= winner ? bus.req1_addr  : bus.req0_addr;
            lat_wdata <= winner ? bus.req1_wdata : bus.req0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !lat_we) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Writes clear the response data so RESP returns 0; reads capture memory at the end of WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == ACCESS && lat_we) begin
            if (lat_id) rdata1 <= '0;
            else        rdata0 <= '0;
        end else if (state == WAIT && wait_cnt == '0) begin
            if (lat_id) rdata1 <= bus.mem_data_out;
            else        rdata0 <= bus.mem_data_out;
        end
    end

    assign bus.req0_ready       = ready[0];
    assign bus.req1_ready       = ready[1];
    assign bus.rsp0_valid       = rsp_valid[0];
    assign bus.rsp1_valid       = rsp_valid[1];
    assign bus.rsp0_rdata       = rdata0;
    assign bus.rsp1_rdata       = rdata1;
    assign bus.mem_address      = lat_addr;
    assign bus.mem_data_in      = lat_wdata;
    assign bus.mem_write_enable = mem_we;
    assign bus.mem_read_enable  = mem_re;
    assign busy                 = (state != IDLE);
    assign state_dbg            = state;
endmodule
